fas_freq_analyzer: RTL and testbench



---
 rtl/fas_pkg.sv | 18 +
 rtl/fas_mag2.sv | 23 ++
 rtl/fas_freq_analyzer.sv | 183 ++++++++++++++++++
 tb/tb_fas_freq_analyzer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// Shared constants and types for the FAS frequency analyzer: frame geometry,
// bin field slices and the scan state encoding.
package fas_pkg;

  localparam int FFT_N    = 16;
  localparam int DW       = 16;
  localparam int REAL_MSB = 31;
  localparam int REAL_LSB = 16;
  localparam int IMAG_MSB = 15;
  localparam int IMAG_LSB = 0;
  localparam int MAG_W    = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

endpackage

// File: rtl/fas_mag2.sv
// Squared magnitude of one packed FFT bin; purely combinational.
// The worst case, -2^15 on both parts, gives exactly 2^31, which fits in 32 unsigned bits.
module fas_mag2
  import fas_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [31:0]      bin_i,
  output logic [MAG_W-1:0] mag_o
);

  logic signed [DW-1:0]    re;
  logic signed [DW-1:0]    im;
  logic signed [MAG_W-1:0] re_sq;
  logic signed [MAG_W-1:0] im_sq;

  assign re    = bin_i[REAL_MSB:REAL_LSB];
  assign im    = bin_i[IMAG_MSB:IMAG_LSB];
  assign re_sq = re * re;
  assign im_sq = im * im;
  assign mag_o = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fas_freq_analyzer.sv
// Captures a parallel 16-bin FFT frame and scans it one bin per cycle for the peak.
// A frame arriving mid-scan is parked in a single pending slot.
module fas_freq_analyzer
  import fas_pkg::*;
#(
  parameter int DW          = 16,
  parameter int SEARCH_BINS = 16,
  parameter bit SKIP_DC     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic        busy,
  output logic        overrun
);

  localparam logic [3:0] FIRST_BIN = SKIP_DC ? 4'd1 : 4'd0;
  localparam logic [3:0] LAST_BIN  = 4'(SEARCH_BINS - 1);

  logic [31:0] bin_in    [FFT_N];
  logic [31:0] active_q  [FFT_N];
  logic [31:0] pending_q [FFT_N];

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [MAG_W-1:0] best_mag_q, best_mag_d;
  logic [3:0]       best_idx_q, best_idx_d;
  logic [3:0]       freq_q, freq_d;
  logic             done_q, done_d;
  logic             pending_vld_q, pending_vld_d;
  logic             overrun_q, overrun_d;

  logic [MAG_W-1:0] mag;
  logic             take;
  logic             load_in;
  logic             load_pend;
  logic             write_pend;

  assign bin_in[0]  = fft_d0;
  assign bin_in[1]  = fft_d1;
  assign bin_in[2]  = fft_d2;
  assign bin_in[3]  = fft_d3;
  assign bin_in[4]  = fft_d4;
  assign bin_in[5]  = fft_d5;
  assign bin_in[6]  = fft_d6;
  assign bin_in[7]  = fft_d7;
  assign bin_in[8]  = fft_d8;
  assign bin_in[9]  = fft_d9;
  assign bin_in[10] = fft_d10;
  assign bin_in[11] = fft_d11;
  assign bin_in[12] = fft_d12;
  assign bin_in[13] = fft_d13;
  assign bin_in[14] = fft_d14;
  assign bin_in[15] = fft_d15;

  fas_mag2 #(.DW(DW)) u_mag2 (
    .bin_i (active_q[idx_q]),
    .mag_o (mag)
  );

  // The first scanned bin always wins so an all-zero frame reports it.
  assign take = (idx_q == FIRST_BIN) || (mag > best_mag_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    best_mag_d    = best_mag_q;
    best_idx_d    = best_idx_q;
    freq_d        = freq_q;
    done_d        = 1'b0;
    pending_vld_d = pending_vld_q;
    overrun_d     = overrun_q;
    load_in       = 1'b0;
    load_pend     = 1'b0;
    write_pend    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fft_valid) begin
          state_d    = CALC;
          load_in    = 1'b1;
          idx_d      = FIRST_BIN;
          best_mag_d = '0;
          best_idx_d = FIRST_BIN;
        end
      end
      CALC: begin
        if (take) begin
          best_mag_d = mag;
          best_idx_d = idx_q;
        end
        if (idx_q == LAST_BIN) begin
          done_d     = 1'b1;
          freq_d     = take ? idx_q : best_idx_q;
          idx_d      = FIRST_BIN;
          best_mag_d = '0;
          best_idx_d = FIRST_BIN;
          // A fresh frame beats the parked one; the parked one is lost.
          if (fft_valid) begin
            load_in = 1'b1;
            if (pending_vld_q) begin
              pending_vld_d = 1'b0;
              overrun_d     = 1'b1;
            end
          end else if (pending_vld_q) begin
            load_pend     = 1'b1;
            pending_vld_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + 4'd1;
          if (fft_valid) begin
            write_pend    = 1'b1;
            pending_vld_d = 1'b1;
            if (pending_vld_q) overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < FFT_N; k++) begin
        active_q[k]  <= '0;
        pending_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < FFT_N; k++) begin
        if (load_in)        active_q[k] <= bin_in[k];
        else if (load_pend) active_q[k] <= pending_q[k];
        if (write_pend)     pending_q[k] <= bin_in[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      best_mag_q    <= '0;
      best_idx_q    <= '0;
      freq_q        <= '0;
      done_q        <= 1'b0;
      pending_vld_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      best_mag_q    <= best_mag_d;
      best_idx_q    <= best_idx_d;
      freq_q        <= freq_d;
      done_q        <= done_d;
      pending_vld_q <= pending_vld_d;
      overrun_q     <= overrun_d;
    end
  end

  assign done    = done_q;
  assign freq    = freq_q;
  assign busy    = (state_q == CALC);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_fas_freq_analyzer.sv
// Scoreboard bench for fas_freq_analyzer: a default instance (A) and a
// SKIP_DC=1, SEARCH_BINS=8 instance (B) share the data bus but not the strobe.
module tb_fas_freq_analyzer;

  logic        clk;
  logic        rst;
  logic        va;
  logic        vb;
  logic [31:0] fd [16];
  logic        done_a, busy_a, ovr_a;
  logic [3:0]  freq_a;
  logic        done_b, busy_b, ovr_b;
  logic [3:0]  freq_b;

  typedef struct {
    int f;
    int t;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fas_freq_analyzer u_dut_a (
    .clk(clk), .rst(rst), .fft_valid(va),
    .fft_d0(fd[0]),   .fft_d1(fd[1]),   .fft_d2(fd[2]),   .fft_d3(fd[3]),
    .fft_d4(fd[4]),   .fft_d5(fd[5]),   .fft_d6(fd[6]),   .fft_d7(fd[7]),
    .fft_d8(fd[8]),   .fft_d9(fd[9]),   .fft_d10(fd[10]), .fft_d11(fd[11]),
    .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
    .done(done_a), .freq(freq_a), .busy(busy_a), .overrun(ovr_a)
  );

  fas_freq_analyzer #(.SEARCH_BINS(8), .SKIP_DC(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .fft_valid(vb),
    .fft_d0(fd[0]),   .fft_d1(fd[1]),   .fft_d2(fd[2]),   .fft_d3(fd[3]),
    .fft_d4(fd[4]),   .fft_d5(fd[5]),   .fft_d6(fd[6]),   .fft_d7(fd[7]),
    .fft_d8(fd[8]),   .fft_d9(fd[9]),   .fft_d10(fd[10]), .fft_d11(fd[11]),
    .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
    .done(done_b), .freq(freq_b), .busy(busy_b), .overrun(ovr_b)
  );

  function automatic void chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && done_a) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done_a: freq %0d with no frame outstanding (cycle %0d)", freq_a, cyc);
      end else begin
        e = qa.pop_front();
        chk("freq_a", int'(freq_a), e.f);
        chk("done_time_a", cyc, e.t);
      end
    end
    if (rst && done_b) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done_b: freq %0d with no frame outstanding (cycle %0d)", freq_b, cyc);
      end else begin
        e = qb.pop_front();
        chk("freq_b", int'(freq_b), e.f);
        chk("done_time_b", cyc, e.t);
      end
    end
  end

  task automatic clr_frame();
    for (int k = 0; k < 16; k++) fd[k] = 32'h0;
  endtask

  task automatic peak_frame(input int p);
    for (int k = 0; k < 16; k++) fd[k] = 32'h0010_0000;
    fd[p] = 32'h0100_0020;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe one frame at the current negedge; f<0 means no result is expected.
  task automatic pulse(input bit to_b, input int f, input int lat);
    exp_t e;
    e.f = f;
    e.t = cyc + lat;
    if (f >= 0) begin
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
    end
    if (to_b) vb = 1'b1;
    else      va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((qa.size() != 0 || qb.size() != 0 || busy_a || busy_b) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(nm, qa.size() + qb.size() + int'(busy_a) + int'(busy_b), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    va  = 1'b1;
    vb  = 1'b1;
    for (int k = 0; k < 16; k++) fd[k] = $urandom();
    repeat (2) @(negedge clk);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_freq_a", int'(freq_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_ovr_a",  int'(ovr_a),  0);
    chk("rst_done_b", int'(done_b), 0);
    chk("rst_freq_b", int'(freq_b), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_ovr_b",  int'(ovr_b),  0);
    va  = 1'b0;
    vb  = 1'b0;
    rst = 1'b1;
    idle(2);

    // Single peak: (3.0, 4.0) in bin 5, done 16 edges after capture.
    clr_frame();
    fd[5] = 32'h0300_0400;
    pulse(1'b0, 5, 17);
    idle(16);
    chk("single_done_now", int'(done_a), 1);
    chk("single_busy_low", int'(busy_a), 0);
    idle(1);
    chk("single_done_once", int'(done_a), 0);
    wait_idle("single_drain");

    // Equal magnitudes of opposite sign: lowest index wins.
    clr_frame();
    fd[3] = 32'hFD00_0000;
    fd[9] = 32'h0300_0000;
    pulse(1'b0, 3, 17);
    wait_idle("tie_drain");

    // Most negative corner (2^31) must beat 0x7FFE0002 without wrapping.
    clr_frame();
    fd[0]  = 32'h7FFF_7FFF;
    fd[14] = 32'h8000_8000;
    pulse(1'b0, 14, 17);
    wait_idle("corner_drain");

    // Frames exactly 16 cycles apart stream without using the pending slot.
    peak_frame(0);
    pulse(1'b0, 0, 17);
    idle(15);
    peak_frame(7);
    pulse(1'b0, 7, 17);
    idle(15);
    peak_frame(15);
    pulse(1'b0, 15, 17);
    wait_idle("stream_drain");
    chk("stream_no_overrun", int'(ovr_a), 0);

    // Second frame at E4 waits in pending and runs right after the first.
    peak_frame(4);
    pulse(1'b0, 4, 17);
    idle(3);
    peak_frame(2);
    pulse(1'b0, 2, 29);
    wait_idle("pending_drain");
    chk("pending_no_overrun", int'(ovr_a), 0);

    // Third frame at E8 overwrites the pending one.
    peak_frame(6);
    pulse(1'b0, 6, 17);
    idle(3);
    peak_frame(2);
    pulse(1'b0, -1, 0);
    idle(3);
    peak_frame(11);
    pulse(1'b0, 11, 25);
    wait_idle("overrun_drain");
    chk("overrun_set", int'(ovr_a), 1);

    // Asynchronous reset in the middle of a scan; that frame never completes.
    peak_frame(9);
    pulse(1'b0, -1, 0);
    idle(5);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_ovr",  int'(ovr_a),  0);
    chk("midrst_freq", int'(freq_a), 0);
    chk("midrst_done", int'(done_a), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Fresh frame on the last-bin edge wins over a parked one.
    peak_frame(1);
    pulse(1'b0, 1, 17);
    idle(3);
    peak_frame(3);
    pulse(1'b0, -1, 0);
    idle(11);
    peak_frame(8);
    pulse(1'b0, 8, 17);
    wait_idle("collide_drain");
    chk("collide_overrun", int'(ovr_a), 1);

    // Instance B: DC ignored, bin 12 beyond the 8-bin window.
    for (int k = 0; k < 16; k++) fd[k] = 32'h0010_0000;
    fd[0]  = 32'h7000_0000;
    fd[6]  = 32'h0200_0000;
    fd[12] = 32'h7FFF_7FFF;
    pulse(1'b1, 6, 8);
    wait_idle("skipdc_drain");
    clr_frame();
    pulse(1'b1, 1, 8);
    wait_idle("zero_drain");
    chk("b_no_overrun", int'(ovr_b), 0);

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
